// File: rtl/audio_pkg.sv
// Shared constants, types and helpers for the microphone frame capture path.
package audio_pkg;

  localparam int unsigned NUM_BINS = 16;
  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned ADC_W    = 12;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 18'h3FFFF;

  // Width of the shifted magnitude: 12-bit magnitude plus up to 8 bits of gain, plus headroom.
  localparam int unsigned GAIN_VW = 21;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT
  } capture_state_t;

  // Clamp a gained magnitude into the sample range.
  function automatic sample_t saturate(input logic [GAIN_VW-1:0] v);
    if (v > GAIN_VW'(SAT_MAX)) begin
      return SAT_MAX;
    end
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sample_conditioner.sv
// Combinational ADC conditioning: remove DC offset, take magnitude, apply gain, saturate.
module sample_conditioner
  import audio_pkg::*;
#(
  parameter int unsigned ADC_MID    = 2048,
  parameter int unsigned GAIN_SHIFT = 6
) (
  input  logic [ADC_W-1:0] adc_data,
  output sample_t          out
);

  logic [ADC_W:0]     diff;
  logic [ADC_W:0]     diff_neg;
  logic [ADC_W-1:0]   mag;
  logic [GAIN_VW-1:0] gained;

  // Signed distance from mid-scale; |d| never exceeds 2048 so it fits in 12 bits.
  always_comb begin
    diff     = {1'b0, adc_data} - (ADC_W + 1)'(ADC_MID);
    diff_neg = '0 - diff;
    mag      = diff[ADC_W] ? diff_neg[ADC_W-1:0] : diff[ADC_W-1:0];
    gained   = {{(GAIN_VW - ADC_W){1'b0}}, mag} << GAIN_SHIFT;
    out      = saturate(gained);
  end

endmodule

// File: rtl/mic_frame_capture.sv
// Captures a 16-sample conditioned frame from the ADC on request and hands it to the top level.
module mic_frame_capture
  import audio_pkg::*;
#(
  parameter int unsigned DECIM          = 1,
  parameter int unsigned GAIN_SHIFT     = 6,
  parameter int unsigned ADC_MID        = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk_25,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         adc_valid,
  input  logic [ADC_W-1:0]             adc_data,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [NUM_BINS*SAMPLE_W-1:0] samples,
  output logic                         clk_sampling
);

  localparam int unsigned DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SLOT_W = $clog2(NUM_BINS);

  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_BINS - 1);

  capture_state_t    state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [TO_W-1:0]   to_q, to_d;
  sample_t           buf_q [NUM_BINS];
  sample_t           buf_d [NUM_BINS];
  sample_t           frame_q [NUM_BINS];
  sample_t           frame_d [NUM_BINS];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              clk_samp_q, clk_samp_d;

  sample_t cond_sample;
  logic    accept;

  sample_conditioner #(
    .ADC_MID    (ADC_MID),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_cond (
    .adc_data (adc_data),
    .out      (cond_sample)
  );

  // A strobe is kept only when it closes a decimation period.
  assign accept = (state_q == CAPTURE) && adc_valid && (dec_q == DEC_LAST);

  // Next-state logic for the FSM, counters, frame buffer and handshake flags.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    dec_d      = dec_q;
    to_d       = to_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    clk_samp_d = clk_samp_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          slot_d  = '0;
          dec_d   = '0;
          to_d    = '0;
          busy_d  = 1'b1;
        end
      end

      CAPTURE: begin
        // The decimation phase runs continuously across slots.
        if (adc_valid) begin
          dec_d = accept ? '0 : dec_q + 1'b1;
        end

        if (accept) begin
          buf_d[slot_q] = cond_sample;
          slot_d        = slot_q + 1'b1;
          clk_samp_d    = ~clk_samp_q;
          to_d          = '0;
          if (slot_q == SLOT_LAST) begin
            state_d = COMMIT;
          end
        end else if (to_q == TO_LAST) begin
          // Abort: the committed frame stays as it was.
          state_d   = IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      COMMIT: begin
        frame_d = buf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      dec_q      <= '0;
      to_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      clk_samp_q <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        buf_q[i]   <= '0;
        frame_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      dec_q      <= dec_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      clk_samp_q <= clk_samp_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
    end
  end

  for (genvar i = 0; i < NUM_BINS; i++) begin : g_pack
    assign samples[i*SAMPLE_W +: SAMPLE_W] = frame_q[i];
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign clk_sampling = clk_samp_q;

endmodule

// File: doc/mic_frame_capture.md
Name: mic_frame_capture

Overview:
- Producer end of the sampler-to-top start/done handshake.
- On a `start` pulse, it collects 16 decimated ADC readings and conditions each one: DC offset removed, magnitude taken, gain applied, saturated to 18 bits.
- It commits the 16-word frame to stable output registers and pulses `done`.
- It feeds the display bar latch in the audio top level.

Parameters:
- DECIM, 1: accept every DECIM-th `adc_valid` strobe. Legal range 1..256.
- GAIN_SHIFT, 6: left shift applied to the magnitude before saturation. Legal range 0..8.
- ADC_MID, 2048: unsigned ADC code treated as zero level.
- TIMEOUT_CYCLES, 1000000: idle `clk_25` cycles allowed between accepted samples before the capture is aborted.

Ports:
- clk_25  input  1  single system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request for a new frame.
- adc_valid  input  1  one-cycle strobe, synchronous to clk_25, marking `adc_data` valid.
- adc_data  input  12  unsigned ADC code.
- busy  output  1  high while a capture is in progress.
- done  output  1  one-cycle pulse when a capture ends, whether completed or timed out.
- timeout  output  1  high together with `done` when the capture was aborted by timeout.
- samples  output  288  committed frame; slot i occupies bits [18i+17:18i].
- clk_sampling  output  1  toggles on every accepted sample (LED/debug).

Behaviour:
- Reset and synchronicity:
  - One clock domain; reset is synchronous and active-high.
  - Reset values: busy=0, done=0, timeout=0, samples=0, clk_sampling=0, state=IDLE, all counters 0, frame buffer 0.
  - Reset mid-capture discards the partial frame. No `done` is issued.
- States: IDLE, CAPTURE, COMMIT.
- IDLE:
  - If start=1, go to CAPTURE.
  - On that transition clear the slot index, decimation counter and timeout counter.
  - busy=1 from the following cycle.
- CAPTURE, decimation:
  - Each adc_valid=1 increments the decimation counter.
  - When the counter equals DECIM-1, the sample is accepted and the counter wraps to 0.
- CAPTURE, accepted sample:
  - Write the conditioned value into buffer[slot].
  - Increment slot.
  - Toggle clk_sampling.
- CAPTURE, end of frame and start handling:
  - Accepting slot 15 moves to COMMIT at the same edge.
  - start is ignored while in CAPTURE and COMMIT.
- CAPTURE, timeout:
  - The timeout counter counts cycles with no accepted sample and resets on each accept.
  - When it reaches TIMEOUT_CYCLES-1, go to IDLE.
  - In the next cycle: done=1, timeout=1, busy=0. `samples` is unchanged.
- COMMIT (one cycle):
  - At the exiting edge, samples <= buffer, done <= 1, busy <= 0, state <= IDLE.
  - Latency: the 16th accept edge is E; samples and done are valid in the cycle after edge E+1.
- Pulse widths and overlap:
  - done and timeout are exactly one cycle wide.
  - start asserted in the same cycle as done is accepted, so frames can run back to back.
  - `samples` holds its value until the next successful commit.
- Conditioning (combinational in front of the buffer write):
  - d = signed 13-bit (adc_data - ADC_MID).
  - m = |d|, 12 bits unsigned, maximum 2048.
  - v = m << GAIN_SHIFT, 21 bits.
  - Output is v if v ≤ 262143, otherwise 262143 (saturate).
- Decimation counter:
  - Cleared on start.
  - Keeps counting across slots; it is not cleared per slot.

Decomposition:
- Package audio_pkg holds:
  - constants NUM_BINS=16, SAMPLE_W=18, ADC_W=12, SAT_MAX=18'h3FFFF;
  - typedef sample_t (logic [SAMPLE_W-1:0]);
  - enum capture_state_t {IDLE, CAPTURE, COMMIT}.
- Sub-module sample_conditioner: purely combinational, with ports adc_data and sample_t out, and parameters ADC_MID and GAIN_SHIFT.
- The FSM, counters and buffer stay in mic_frame_capture.

Test Plan:
- Basic frame: rst, then start, DECIM=1, 16 strobes with adc_data = 2048+k*100 for k=0..15 -> done once, 2 cycles after the 16th strobe edge; slot k = (k*100)<<6 (slot 15 = 96000); busy low at done; clk_sampling toggled 16 times.
- Sign and saturation:
  - adc_data=0 with GAIN_SHIFT=6 -> 131072.
  - adc_data=0 with GAIN_SHIFT=7 -> 262143 (saturated).
  - adc_data=4095 with GAIN_SHIFT=6 -> 2047<<6 = 131008.
- Decimation: DECIM=4, 64 strobes with adc_data = strobe index n -> slot k holds conditioned value of n=4k+3; done only after the 64th strobe.
- Timeout: TIMEOUT_CYCLES=50, start, 5 strobes, then silence -> done=timeout=1 for one cycle, 50 cycles after the last accept; samples equal the previous frame.
- Start ignored and reset mid-capture: pulse start during CAPTURE -> no restart, slot count continues. Assert rst after 8 samples -> no done, samples=0; a new start then yields a full correct frame.
- Back-to-back: assert start in the same cycle as done -> the second capture begins; the first frame stays on `samples` until the second commit.
